// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard scoreboard.
package pipe_pkg;
  localparam int WB_DEPTH_DEF = 3;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] LAT_ALU     = 2'd1;
  localparam logic [1:0] LAT_LOAD    = 2'd2;

  typedef logic [$clog2(WB_DEPTH_DEF+1)-1:0] fwd_sel_t;
endpackage

// File: rtl/pipe_scoreboard_sb_entry.sv
// One scoreboard entry: tracks a single in-flight write to one architectural register.
module sb_entry
  import pipe_pkg::*;
#(
  parameter int LW  = 2,
  parameter int AGW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set,
  input  logic [LW-1:0]  lat,
  input  logic           clear,
  output logic           pend,
  output logic           wait_nz,
  output logic [AGW-1:0] age
);
  logic [LW-1:0] wait_cnt;

  // A new producer always overrides the ageing of an older one (youngest owns the entry).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      age      <= '0;
      wait_cnt <= '0;
    end else if (set) begin
      pend     <= 1'b1;
      age      <= AGW'(1);
      wait_cnt <= (lat == '0) ? '0 : lat - LW'(1);
    end else if (pend) begin
      if (clear) begin
        pend     <= 1'b0;
        age      <= '0;
        wait_cnt <= '0;
      end else begin
        age      <= age + AGW'(1);
        wait_cnt <= (wait_cnt == '0) ? '0 : wait_cnt - LW'(1);
      end
    end
  end

  assign wait_nz = (wait_cnt != '0);
endmodule

// File: rtl/pipe_scoreboard.sv
// ID-stage hazard scoreboard: per-register in-flight tracking, issue stall and EX forward selects.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NSRC     = 2,
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  parameter int LW       = $clog2(WB_DEPTH+1),
  parameter int AGW      = $clog2(WB_DEPTH+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  issue_valid_i,
  input  logic                  issue_we_i,
  input  logic [AW-1:0]         issue_rd_i,
  input  logic [LW-1:0]         issue_lat_i,
  input  logic [NSRC*AW-1:0]    src_addr_i,
  input  logic [NSRC-1:0]       src_used_i,
  output logic                  stall_o,
  output logic [NSRC*AGW-1:0]   fwd_sel_o,
  output logic [NREG-1:0]       busy_o
);
  logic [NREG-1:0] pend;
  logic [NREG-1:0] wait_nz;
  logic [NREG-1:0] set;
  logic [NREG-1:0] retire;
  logic [AGW-1:0]  age [NREG];
  logic [NSRC-1:0] hazard;
  logic [AW-1:0]   src;
  logic [LW-1:0]   lat_clamped;
  logic            accept;

  assign lat_clamped = (issue_lat_i > LW'(WB_DEPTH)) ? LW'(WB_DEPTH) : issue_lat_i;

  // Sources look at pre-edge state only, so an instruction never waits on its own write.
  always_comb begin
    hazard    = '0;
    fwd_sel_o = '0;
    src       = '0;
    for (int k = 0; k < NSRC; k++) begin
      src = src_addr_i[k*AW +: AW];
      if (src != '0 && pend[src]) begin
        fwd_sel_o[k*AGW +: AGW] = age[src];
        hazard[k]               = issue_valid_i & src_used_i[k] & wait_nz[src];
      end
    end
  end

  assign stall_o = (|hazard) & ~flush_i;
  assign accept  = issue_valid_i & ~stall_o & ~flush_i & issue_we_i & (issue_rd_i != '0);

  // Entry retires on the edge where it would reach WB_DEPTH; the register file covers it then.
  for (genvar r = 0; r < NREG; r++) begin : g_entry
    assign set[r]    = accept & (issue_rd_i == AW'(r));
    assign retire[r] = (age[r] == AGW'(WB_DEPTH-1));

    sb_entry #(.LW(LW), .AGW(AGW)) u_entry (
      .clk     (clk_i),
      .rst     (rst_i),
      .set     (set[r]),
      .lat     (lat_clamped),
      .clear   (retire[r]),
      .pend    (pend[r]),
      .wait_nz (wait_nz[r]),
      .age     (age[r])
    );
  end

  assign busy_o = pend;
endmodule
